// File: rtl/arb_pkg.sv
// Shared arbiter definitions: FSM state encoding, default timeout and a
// saturating increment helper for the optional wait counters.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GNT_DM = 2'b01,
    GNT_IF = 2'b10
  } arb_state_e;

  localparam int MAX_WAIT_DEFAULT = 15;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic inc);
    return (inc && (v != '1)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port, memory side and status signals.
// The arbiter connects through the slave modport; requesters/memory through master.
interface mem_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic        stall_if;
  logic        stall_mem;
  logic        bus_err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, dm_rdata, dm_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output stall_if, stall_mem, bus_err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, dm_rdata, dm_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  stall_if, stall_mem, bus_err
  );

endinterface

// File: rtl/arb_wait_timer.sv
// 8-bit wait counter for one memory access; expired flags the last allowed
// not-ready cycle so the arbiter aborts on that same edge.
module arb_wait_timer
  import arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt_q;

  assign expired = en && (cnt_q == 8'(MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) memory arbiter with alternating tie-break and access timeout.
// Define ARB_PERF_EN to add the perf_if_wait/perf_dm_wait stall counters.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]  perf_if_wait,
  output logic [31:0]  perf_dm_wait
`endif
);

  arb_state_e  state_q;
  logic        last_dm_q;
  logic        mem_en_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] dm_rdata_q;
  logic        if_ack_q;
  logic        dm_ack_q;
  logic        bus_err_q;

  logic        pend_if;
  logic        pend_dm;
  logic        pick_dm;
  logic        granted;
  logic        expired;
  logic [31:0] resp_data;

  // A request whose ack is still high is being dropped and must not be re-granted.
  assign pend_if   = bus.if_req & ~if_ack_q;
  assign pend_dm   = bus.dm_req & ~dm_ack_q;
  assign pick_dm   = pend_dm & (~pend_if | ~last_dm_q);
  assign granted   = (state_q != IDLE);
  assign resp_data = bus.mem_ready ? bus.mem_rdata : '0;

  arb_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (~granted),
    .en     (granted & ~bus.mem_ready),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_dm_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      if_ack_q  <= 1'b0;
      dm_ack_q  <= 1'b0;
      bus_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pend_dm || pend_if) begin
            state_q     <= pick_dm ? GNT_DM : GNT_IF;
            mem_en_q    <= 1'b1;
            mem_we_q    <= pick_dm & bus.dm_we;
            mem_addr_q  <= pick_dm ? bus.dm_addr : bus.if_addr;
            mem_wdata_q <= pick_dm ? bus.dm_wdata : '0;
          end
        end
        GNT_DM, GNT_IF: begin
          // Completion and timeout share one exit; timeout returns zero data.
          if (bus.mem_ready || expired) begin
            state_q   <= IDLE;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            last_dm_q <= (state_q == GNT_DM);
            bus_err_q <= expired;
            if (state_q == GNT_DM) begin
              dm_rdata_q <= resp_data;
              dm_ack_q   <= 1'b1;
            end else begin
              if_rdata_q <= resp_data;
              if_ack_q   <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.stall_if  = bus.if_req & ~if_ack_q;
  assign bus.stall_mem = bus.dm_req & ~dm_ack_q;

`ifdef ARB_PERF_EN
  logic [31:0] perf_if_q;
  logic [31:0] perf_dm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_q <= '0;
      perf_dm_q <= '0;
    end else begin
      perf_if_q <= sat_inc32(perf_if_q, bus.if_req & ~if_ack_q);
      perf_dm_q <= sat_inc32(perf_dm_q, bus.dm_req & ~dm_ack_q);
    end
  end

  assign perf_if_wait = perf_if_q;
  assign perf_dm_wait = perf_dm_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter; the bench plays both requesters
// and the memory, predicting grants, latencies and data from a transaction model.
module tb_mem_arbiter;

  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

`ifdef ARB_PERF_EN
  logic [31:0] perf_if_wait;
  logic [31:0] perf_dm_wait;
`endif

  mem_arbiter #(
    .MAX_WAIT(MW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ARB_PERF_EN
    ,
    .perf_if_wait(perf_if_wait),
    .perf_dm_wait(perf_dm_wait)
`endif
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          n_txn = 0;
  bit          last_dm_m;
  logic [31:0] mem_m [8];
  logic [31:0] if_rd_m;
  logic [31:0] dm_rd_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_en",    32'(bus.mem_en), 0);
    check("rst_we",    32'(bus.mem_we), 0);
    check("rst_addr",  bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_pulse", 32'({bus.if_ack, bus.dm_ack, bus.bus_err}), 0);
    check("rst_if_rd", bus.if_rdata, 0);
    check("rst_dm_rd", bus.dm_rdata, 0);
`ifdef ARB_PERF_EN
    check("rst_perf", perf_if_wait | perf_dm_wait, 0);
`endif
    rst = 1'b0;
    last_dm_m = 1'b0;
    if_rd_m = '0;
    dm_rd_m = '0;
  endtask

  task automatic idle();
    @(negedge clk);
    check("idle_en",    32'(bus.mem_en), 0);
    check("idle_pulse", 32'({bus.if_ack, bus.dm_ack, bus.bus_err}), 0);
  endtask

  // Called at the negedge before the expected grant edge; returns on the ack negedge.
  task automatic serve(input bit to_dm, input int lat, input bit jitter);
    logic [31:0] a, wd, rd, exp_rd;
    bit we, tmo;
    int n;
    a   = to_dm ? bus.dm_addr : bus.if_addr;
    we  = to_dm & bus.dm_we;
    wd  = bus.dm_wdata;
    tmo = (lat >= MW);
    rd  = we ? $urandom : mem_m[a[4:2]];
    @(negedge clk);
    check("grant_en",   32'(bus.mem_en), 1);
    check("grant_addr", bus.mem_addr, a);
    check("grant_we",   32'(bus.mem_we), 32'(we));
    if (we) check("grant_wdata", bus.mem_wdata, wd);
    check("grant_ack",   32'({bus.if_ack, bus.dm_ack}), 0);
    check("grant_stall", 32'(to_dm ? bus.stall_mem : bus.stall_if), 1);
    bus.mem_rdata = rd;
    bus.mem_ready = (lat == 0);
    n = tmo ? MW : lat + 1;
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      check("hold_en",    32'(bus.mem_en), 1);
      check("hold_addr",  bus.mem_addr, a);
      check("hold_we",    32'(bus.mem_we), 32'(we));
      if (we) check("hold_wdata", bus.mem_wdata, wd);
      check("wait_pulse", 32'({bus.bus_err, bus.if_ack, bus.dm_ack}), 0);
      bus.mem_ready = (k == lat);
      if (jitter && ($urandom_range(0, 3) == 0)) begin
        if (to_dm) bus.dm_addr = $urandom; else bus.if_addr = $urandom;
      end
      if (jitter && ($urandom_range(0, 7) == 0)) begin
        if (to_dm) bus.dm_req = 1'b0; else bus.if_req = 1'b0;
      end
    end
    @(negedge clk);
    exp_rd = tmo ? 32'd0 : rd;
    if (to_dm) dm_rd_m = exp_rd; else if_rd_m = exp_rd;
    if (we && !tmo) mem_m[a[4:2]] = wd;
    last_dm_m = to_dm;
    check("done_dm_ack", 32'(bus.dm_ack), 32'(to_dm));
    check("done_if_ack", 32'(bus.if_ack), 32'(!to_dm));
    check("done_err",    32'(bus.bus_err), 32'(tmo));
    check("done_en",     32'(bus.mem_en), 0);
    check("if_rdata",    bus.if_rdata, if_rd_m);
    check("dm_rdata",    bus.dm_rdata, dm_rd_m);
    check("stall_if",    32'(bus.stall_if), 32'(bus.if_req & to_dm));
    check("stall_mem",   32'(bus.stall_mem), 32'(bus.dm_req & !to_dm));
    n_txn++;
    $display("txn %0d port=%s we=%0d addr=%h lat=%0d timeout=%0d rdata=%h",
             n_txn, to_dm ? "DM" : "IF", we, a, lat, tmo, exp_rd);
    // Memory may leave ready high while idle; the arbiter must ignore it.
    bus.mem_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    bit to_dm;
    bit pend_if;
    bit pend_dm;
    int m;

    for (int i = 0; i < 8; i++) mem_m[i] = 32'hC0DE_0000 | 32'(i);
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
    do_reset();

    // Data write with three not-ready cycles.
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h100;
    bus.dm_wdata = 32'hDEAD_BEEF;
    bus.dm_req   = 1'b1;
    serve(1'b1, 3, 1'b0);
`ifdef ARB_PERF_EN
    check("perf_dm_wait", perf_dm_wait, 5);
    check("perf_if_wait", perf_if_wait, 0);
`endif
    bus.dm_req = 1'b0;
    idle();

    // Single fetch, zero-wait memory.
    mem_m[0]    = 32'h1234_5678;
    bus.if_addr = 32'h40;
    bus.if_req  = 1'b1;
    serve(1'b0, 0, 1'b0);
    check("fetch_data", bus.if_rdata, 32'h1234_5678);
    bus.if_req = 1'b0;
    idle();

    // Timeout on a data read.
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h8;
    bus.dm_req  = 1'b1;
    serve(1'b1, MW + 3, 1'b0);
    check("tmo_rdata", bus.dm_rdata, 0);
    bus.dm_req = 1'b0;
    idle();

    // Both requests held from reset: grants must alternate starting with DM.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h14;
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h18;
    do_reset();
    for (int g = 0; g < 4; g++) serve(!last_dm_m, 0, 1'b0);
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    idle();

    // Reset in the middle of a fetch grant.
    bus.if_addr = 32'h80;
    bus.if_req  = 1'b1;
    @(negedge clk);
    check("pre_rst_en", 32'(bus.mem_en), 1);
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_en",  32'(bus.mem_en), 0);
    check("mid_rst_ack", 32'(bus.if_ack), 0);
    check("mid_rst_rd",  bus.if_rdata, 0);
    rst = 1'b0;
    last_dm_m = 1'b0;
    if_rd_m = '0;
    dm_rd_m = '0;
    serve(1'b0, 2, 1'b0);
    bus.if_req = 1'b0;
    idle();

    // Random batches of single and simultaneous requests.
    for (int b = 0; b < 60; b++) begin
      m = $urandom_range(1, 3);
      pend_if = m[0];
      pend_dm = m[1];
      if (pend_if) begin
        bus.if_addr = $urandom & 32'h0000_0F1C;
        bus.if_req  = 1'b1;
      end
      if (pend_dm) begin
        bus.dm_addr  = $urandom & 32'h0000_0F1C;
        bus.dm_we    = 1'($urandom_range(0, 1));
        bus.dm_wdata = $urandom;
        bus.dm_req   = 1'b1;
      end
      while (pend_if || pend_dm) begin
        to_dm = pend_dm && (!pend_if || !last_dm_m);
        serve(to_dm, $urandom_range(0, MW + 1), 1'b1);
        if (to_dm) begin
          bus.dm_req = 1'b0;
          pend_dm = 1'b0;
        end else begin
          bus.if_req = 1'b0;
          pend_if = 1'b0;
        end
      end
      idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum wait cycles per access before abort; legal range 1..255.
REQ-002 Ports, clock and reset first:
- clk  in  1  the single clock.
- rst  in  1  synchronous, active-high reset.
REQ-003 Fetch port:
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetch data.
- if_ack  out  1  one-cycle completion pulse.
REQ-004 Data port:
- dm_req  in  1  data request, held until dm_ack.
- dm_we  in  1  1 = write.
- dm_addr  in  32  data address.
- dm_wdata  in  32  write data.
- dm_rdata  out  32  read data.
- dm_ack  out  1  one-cycle completion pulse.
REQ-005 Memory side:
- mem_en  out  1  access active.
- mem_we  out  1  write strobe.
- mem_addr  out  32  address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data.
- mem_ready  in  1  access complete this cycle.
REQ-006 Status:
- stall_if  out  1  equals if_req & ~if_ack.
- stall_mem  out  1  equals dm_req & ~dm_ack.
- bus_err  out  1  one-cycle pulse, coincident with the ack of a timed-out access.

Function
REQ-007 The FSM SHALL have exactly three states: IDLE, GNT_DM, GNT_IF.
REQ-008 In IDLE, a request whose ack is currently high SHALL be ignored; this prevents re-granting a request that is being dropped.
REQ-009 Grant rule in IDLE:
- Only dm_req pending: go to GNT_DM.
- Only if_req pending: go to GNT_IF.
- Both pending: grant the port not served last (last_dm flag); after reset last_dm=0, so DM wins the first tie.
REQ-010 On the grant edge, the arbiter SHALL latch the granted port's addr, we and wdata into mem_addr, mem_we and mem_wdata. For GNT_IF, mem_we=0. These values SHALL stay stable for the whole grant.
REQ-011 mem_en SHALL be 1 exactly while in GNT_DM or GNT_IF.
REQ-012 While in a grant state, the arbiter SHALL increment an 8-bit wait counter each cycle that mem_ready=0. The counter SHALL clear on every grant.
REQ-013 On the edge where mem_ready=1 is sampled in a grant state:
- the granted port's rdata <= mem_rdata;
- the granted port's ack <= 1 for one cycle;
- last_dm is updated;
- the state returns to IDLE.
Minimum access latency is therefore request -> ack = 2 cycles.
REQ-014 Timeout: if the wait counter reaches MAX_WAIT with mem_ready=0, the access SHALL abort:
- rdata <= 0;
- ack and bus_err pulse together for one cycle;
- the state returns to IDLE.
REQ-015 mem_ready sampled in IDLE SHALL be ignored.
REQ-016 rdata registers SHALL hold their value until the next completion on the same port.
REQ-017 Request or address changes during a grant SHALL be ignored. A request dropped mid-grant still completes and still pulses ack.
REQ-018 stall_if and stall_mem SHALL be combinational, with no register delay.

Reset
REQ-019 When rst=1 at a clock edge, the arbiter SHALL apply all of the following, aborting any in-flight access without an ack:
- state <= IDLE, last_dm <= 0, wait counter <= 0;
- mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0;
- if_ack=0, dm_ack=0, bus_err=0;
- if_rdata=0, dm_rdata=0.

Configuration
REQ-020 Macro ARB_PERF_EN controls two extra outputs, perf_if_wait and perf_dm_wait (32 bits each).
- Each counter increments every cycle its stall signal is 1; it saturates at all-ones and clears on rst.
- Without ARB_PERF_EN, the ports and counters SHALL be absent and all other behaviour is identical.

Structure
REQ-021 Shared package arb_pkg SHALL hold the state encoding constants (IDLE=2'b00, GNT_DM=2'b01, GNT_IF=2'b10) and the MAX_WAIT default.
REQ-022 The wait counter and timeout compare SHALL be one sub-module, arb_wait_timer (inputs: clk, rst, clr, en; output: expired).

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Single fetch, if_addr=0x40, mem_ready tied 1, mem_rdata=0x1234_5678 -> if_ack high 2 cycles after if_req; if_rdata=0x12345678; mem_we=0 throughout.
- dm_req and if_req both asserted from reset, mem_ready=1 -> grants in order DM, IF, DM, IF; each ack is a single-cycle pulse.
- dm write, addr=0x100, wdata=0xDEADBEEF, mem_ready delayed 3 cycles -> mem_en, mem_we, mem_addr and mem_wdata stable for 4 cycles; dm_ack on the 5th cycle after grant.
- MAX_WAIT=4, mem_ready held 0 -> access aborts after 4 wait cycles; dm_ack and bus_err pulse together; dm_rdata=0.
- rst=1 asserted mid-GNT_IF -> next cycle mem_en=0, no if_ack; with if_req still high, the next grant follows after rst drops.
- With ARB_PERF_EN defined, the 3-cycle-delay scenario -> perf_dm_wait=5 after dm_ack.
